// File: rtl/core_defines.sv
// Shared register-file definitions: default widths, zero constants and
// helpers for slicing flattened multi-port buses.
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package core_defines;
   localparam int DEF_DW   = 32;
   localparam int DEF_NREG = 32;
   localparam int DEF_AW   = $clog2(DEF_NREG);

   typedef logic [DEF_DW-1:0] reg_bus_t;
   typedef logic [DEF_AW-1:0] reg_addr_bus_t;

   localparam reg_bus_t      ZeroWord = '0;
   localparam reg_addr_bus_t ZeroReg  = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: issue allocates, write-back releases, flush
// clears everything. Also keeps a registered count of busy registers.
module regfile_scoreboard
   import core_defines::*;
#(
   parameter int NREG     = 32,
   parameter int AW       = $clog2(NREG),
   parameter int NW       = 2,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [NW-1:0]    wen,
   input  logic [NW*AW-1:0] waddr,
   input  logic [NW-1:0]    alloc_en,
   input  logic [NW*AW-1:0] alloc_addr,
   output logic [NREG-1:0]  busy,
   output logic [AW:0]      busy_cnt
);

   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] busy_nxt_s;
   logic [AW:0]     cnt_r;
   logic [AW:0]     cnt_nxt_s;
   logic            alloc_hit_s;
   logic            rel_hit_s;

   // Next-state busy bits: flush beats allocation, allocation beats release.
   always_comb begin
      busy_nxt_s  = '0;
      cnt_nxt_s   = '0;
      alloc_hit_s = 1'b0;
      rel_hit_s   = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         alloc_hit_s = 1'b0;
         rel_hit_s   = 1'b0;
         for (int k = 0; k < NW; k++) begin
            alloc_hit_s = alloc_hit_s | (alloc_en[k] && (`RF_SLICE(alloc_addr, k, AW) == AW'(r)));
            rel_hit_s   = rel_hit_s   | (wen[k]      && (`RF_SLICE(waddr, k, AW)      == AW'(r)));
         end
         busy_nxt_s[r] = ((ZERO_REG != 0) && (AW'(r) == AW'(ZeroReg))) ? 1'b0 :
                         flush       ? 1'b0 :
                         alloc_hit_s ? 1'b1 :
                         rel_hit_s   ? 1'b0 : busy_r[r];
         cnt_nxt_s = cnt_nxt_s + (AW+1)'(busy_nxt_s[r]);
      end
   end

   // Busy vector and its population count, both cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= '0;
         cnt_r  <= '0;
      end else begin
         busy_r <= busy_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   assign busy     = busy_r;
   assign busy_cnt = cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write forwarding,
// optional hard-zero register 0 and a busy scoreboard.
module regfile_mp
   import core_defines::*;
#(
   parameter int DW       = 32,
   parameter int NREG     = 32,
   parameter int AW       = $clog2(NREG),
   parameter int NR       = 4,
   parameter int NW       = 2,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NR*AW-1:0] raddr,
   output logic [NR*DW-1:0] rdata,
   output logic [NR-1:0]    rbusy,
   input  logic [NW-1:0]    wen,
   input  logic [NW*AW-1:0] waddr,
   input  logic [NW*DW-1:0] wdata,
   input  logic [NW-1:0]    alloc_en,
   input  logic [NW*AW-1:0] alloc_addr,
   input  logic             flush,
   output logic [AW:0]      busy_cnt
);

   logic [DW-1:0]   mem_r [NREG];
   logic [NREG-1:0] busy_s;
   logic [DW-1:0]   rd_s;
   logic            hit_s;
   logic [AW-1:0]   ra_s;

   regfile_scoreboard #(
      .NREG     (NREG),
      .AW       (AW),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .wen        (wen),
      .waddr      (waddr),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .busy       (busy_s),
      .busy_cnt   (busy_cnt)
   );

   // Storage update; later (higher-indexed) ports override earlier ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            mem_r[r] <= DW'(ZeroWord);
         end
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (wen[j] && !((ZERO_REG != 0) && (`RF_SLICE(waddr, j, AW) == AW'(ZeroReg)))) begin
               mem_r[`RF_SLICE(waddr, j, AW)] <= `RF_SLICE(wdata, j, DW);
            end
         end
      end
   end

   // Read ports: reset, hard zero, forwarded write data, then stored entry.
   always_comb begin
      rdata = '0;
      rbusy = '0;
      rd_s  = DW'(ZeroWord);
      hit_s = 1'b0;
      ra_s  = AW'(ZeroReg);
      for (int i = 0; i < NR; i++) begin
         ra_s  = `RF_SLICE(raddr, i, AW);
         rd_s  = mem_r[ra_s];
         hit_s = 1'b0;
         for (int j = 0; j < NW; j++) begin
            rd_s  = (wen[j] && (`RF_SLICE(waddr, j, AW) == ra_s)) ? `RF_SLICE(wdata, j, DW) : rd_s;
            hit_s = hit_s | (wen[j] && (`RF_SLICE(waddr, j, AW) == ra_s));
         end
         if (rst) begin
            `RF_SLICE(rdata, i, DW) = DW'(ZeroWord);
            rbusy[i]                = 1'b0;
         end else if ((ZERO_REG != 0) && (ra_s == AW'(ZeroReg))) begin
            `RF_SLICE(rdata, i, DW) = DW'(ZeroWord);
            rbusy[i]                = 1'b0;
         end else begin
            `RF_SLICE(rdata, i, DW) = rd_s;
            rbusy[i]                = busy_s[ra_s] & ~hit_s;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, a short
// hand-written scoreboard sequence, then randomized traffic against a model.
module tb_regfile_mp;
   localparam int DW = 32, NREG = 32, AW = 5, NR = 4, NW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic [NW-1:0]    wen;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NW-1:0]    alloc_en;
   logic [NW*AW-1:0] alloc_addr;
   logic             flush;
   logic [AW:0]      busy_cnt;

   regfile_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .flush(flush), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_mem  [NREG];
   bit          m_busy [NREG];

   typedef struct {
      logic        rst;
      logic [1:0]  wen;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [1:0]  ae;
      logic [4:0]  aa0, aa1;
      logic        flush;
      logic [4:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_rb;
      logic [5:0]  exp_cnt;
   } vec_t;

   vec_t vec [24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1, input logic [1:0] ae,
                        input logic [4:0] aa0, input logic [4:0] aa1, input logic fl,
                        input logic [NR*AW-1:0] ra);
      rst        = r;
      wen        = we;
      waddr      = {wa1, wa0};
      wdata      = {wd1, wd0};
      alloc_en   = ae;
      alloc_addr = {aa1, aa0};
      flush      = fl;
      raddr      = ra;
   endtask

   // Reference read value from the current inputs and model state.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (rst) return 32'd0;
      if (a == 5'd0) return 32'd0;
      for (int j = NW - 1; j >= 0; j--)
         if (wen[j] && waddr[j*AW +: AW] == a) return wdata[j*DW +: DW];
      return m_mem[a];
   endfunction

   function automatic logic exp_rb(input logic [4:0] a);
      if (rst) return 1'b0;
      for (int j = 0; j < NW; j++)
         if (wen[j] && waddr[j*AW +: AW] == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [5:0] model_cnt();
      int c = 0;
      for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
      return 6'(c);
   endfunction

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = 32'd0;
            m_busy[r] = 1'b0;
         end
      end else begin
         for (int j = 0; j < NW; j++)
            if (wen[j] && waddr[j*AW +: AW] != 5'd0) m_mem[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
         if (flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
         end else begin
            for (int j = 0; j < NW; j++)
               if (wen[j]) m_busy[waddr[j*AW +: AW]] = 1'b0;
            for (int k = 0; k < NW; k++)
               if (alloc_en[k] && alloc_addr[k*AW +: AW] != 5'd0) m_busy[alloc_addr[k*AW +: AW]] = 1'b1;
         end
      end
   endtask

   // One cycle with constant expectations on every read port and busy_cnt.
   task automatic run_cycle(input string nm, input logic [31:0] erd, input logic erb, input logic [5:0] ecnt);
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         chk({nm, "_rdata"}, rdata[i*DW +: DW], erd);
         chk({nm, "_rbusy"}, 32'(rbusy[i]), 32'(erb));
      end
      @(posedge clk);
      model_edge();
      #1;
      chk({nm, "_busy_cnt"}, 32'(busy_cnt), 32'(ecnt));
   endtask

   initial begin
      //          rst   wen    wa0    wa1   wd0            wd1     ae     aa0    aa1   fl    ra     exp_rd         rb    cnt
      vec[0]  = '{1'b1, 2'b01, 5'd5,  5'd0, 32'hDEAD,      32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd5,  32'h0,         1'b0, 6'd0};
      vec[1]  = '{1'b1, 2'b01, 5'd5,  5'd0, 32'hDEAD,      32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd5,  32'h0,         1'b0, 6'd0};
      vec[2]  = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd5,  32'h0,         1'b0, 6'd0};
      vec[3]  = '{1'b0, 2'b01, 5'd3,  5'd0, 32'h12345678,  32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd3,  32'h12345678,  1'b0, 6'd0};
      vec[4]  = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd3,  32'h12345678,  1'b0, 6'd0};
      vec[5]  = '{1'b0, 2'b11, 5'd7,  5'd7, 32'hA,         32'hB,  2'b00, 5'd0,  5'd0, 1'b0, 5'd7,  32'hB,         1'b0, 6'd0};
      vec[6]  = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd7,  32'hB,         1'b0, 6'd0};
      vec[7]  = '{1'b0, 2'b01, 5'd0,  5'd0, 32'hFF,        32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 6'd0};
      vec[8]  = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 6'd0};
      vec[9]  = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b01, 5'd9,  5'd0, 1'b0, 5'd9,  32'h0,         1'b0, 6'd1};
      vec[10] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd9,  32'h0,         1'b1, 6'd1};
      vec[11] = '{1'b0, 2'b01, 5'd9,  5'd0, 32'h99,        32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd9,  32'h99,        1'b0, 6'd0};
      vec[12] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b01, 5'd4,  5'd0, 1'b0, 5'd4,  32'h0,         1'b0, 6'd1};
      vec[13] = '{1'b0, 2'b01, 5'd4,  5'd0, 32'h44,        32'h0,  2'b10, 5'd0,  5'd4, 1'b0, 5'd4,  32'h44,        1'b0, 6'd1};
      vec[14] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd4,  32'h44,        1'b1, 6'd1};
      vec[15] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b11, 5'd1,  5'd2, 1'b0, 5'd4,  32'h44,        1'b1, 6'd3};
      vec[16] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b11, 5'd3,  5'd5, 1'b0, 5'd4,  32'h44,        1'b1, 6'd5};
      vec[17] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b11, 5'd6,  5'd6, 1'b0, 5'd6,  32'h0,         1'b0, 6'd6};
      vec[18] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b01, 5'd8,  5'd0, 1'b1, 5'd6,  32'h0,         1'b1, 6'd0};
      vec[19] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd6,  32'h0,         1'b0, 6'd0};
      vec[20] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b01, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 6'd0};
      vec[21] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 6'd0};
      vec[22] = '{1'b1, 2'b01, 5'd10, 5'd0, 32'h77,        32'h0,  2'b01, 5'd10, 5'd0, 1'b0, 5'd10, 32'h0,         1'b0, 6'd0};
      vec[23] = '{1'b0, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0,  2'b00, 5'd0,  5'd0, 1'b0, 5'd4,  32'h0,         1'b0, 6'd0};

      for (int r = 0; r < NREG; r++) begin
         m_mem[r]  = 32'd0;
         m_busy[r] = 1'b0;
      end

      for (int v = 0; v < 24; v++) begin
         drive(vec[v].rst, vec[v].wen, vec[v].wa0, vec[v].wa1, vec[v].wd0, vec[v].wd1,
               vec[v].ae, vec[v].aa0, vec[v].aa1, vec[v].flush, {NR{vec[v].ra}});
         run_cycle($sformatf("vec%0d", v), vec[v].exp_rd, vec[v].exp_rb, vec[v].exp_cnt);
      end

      // Release and re-allocate the same register in one cycle, then flush.
      drive(1'b0, 2'b00, 5'd0,  5'd0, 32'h0,  32'h0, 2'b01, 5'd15, 5'd0, 1'b0, {NR{5'd15}});
      run_cycle("realloc_a", 32'h0, 1'b0, 6'd1);
      drive(1'b0, 2'b01, 5'd15, 5'd0, 32'h55, 32'h0, 2'b01, 5'd15, 5'd0, 1'b0, {NR{5'd15}});
      run_cycle("realloc_b", 32'h55, 1'b0, 6'd1);
      drive(1'b0, 2'b00, 5'd0,  5'd0, 32'h0,  32'h0, 2'b00, 5'd0,  5'd0, 1'b0, {NR{5'd15}});
      run_cycle("realloc_c", 32'h55, 1'b1, 6'd1);
      drive(1'b0, 2'b00, 5'd0,  5'd0, 32'h0,  32'h0, 2'b00, 5'd0,  5'd0, 1'b1, {NR{5'd15}});
      run_cycle("realloc_d", 32'h55, 1'b1, 6'd0);
      drive(1'b0, 2'b00, 5'd0,  5'd0, 32'h0,  32'h0, 2'b00, 5'd0,  5'd0, 1'b0, {NR{5'd15}});
      run_cycle("realloc_e", 32'h55, 1'b0, 6'd0);

      // Randomized traffic on a narrow address range to force conflicts.
      for (int n = 0; n < 400; n++) begin
         logic [NR*AW-1:0] ra;
         for (int i = 0; i < NR; i++) ra[i*AW +: AW] = 5'($urandom_range(0, 15));
         drive(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), $urandom, $urandom,
               2'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
               ($urandom_range(0, 15) == 0), ra);
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("rand%0d_rdata%0d", n, i), rdata[i*DW +: DW], exp_rd(raddr[i*AW +: AW]));
            chk($sformatf("rand%0d_rbusy%0d", n, i), 32'(rbusy[i]), 32'(exp_rb(raddr[i*AW +: AW])));
         end
         @(posedge clk);
         model_edge();
         #1;
         chk($sformatf("rand%0d_busy_cnt", n), 32'(busy_cnt), 32'(model_cnt()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
